// File: rtl/fft_ctrl.sv
// Control sequencer for a 32-point, two-lane MDC FFT pipeline: tracks frames and
// delays per-stage commutator/butterfly strobes. FFT_CTRL_ERR_EN enables frame_err.
module fft_ctrl #(
  parameter int L2       = 16,
  parameter int L3       = 32,
  parameter int L4       = 40,
  parameter int L5       = 44,
  parameter int PIPE_LAT = 46
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [4:0] state_com_mode,
  output logic [4:0] butter_mode,
  output logic       state5_com_flag,
  output logic       out_valid,
  output logic       out_last,
  output logic       frame_err
);

  localparam int FW = $clog2(PIPE_LAT + 1);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_e;

  typedef struct packed {
    logic       vld;
    logic [3:0] cnt;
  } tap_t;

  state_e        state_q;
  logic [3:0]    in_cnt_q;
  logic [FW-1:0] flush_q;
  tap_t          dl_q [1:PIPE_LAT];
  logic          abort;
  logic          in_act;

  // A gap inside a frame drops the partial frame; in_cnt is only nonzero mid-frame.
  assign abort  = ~in_valid & (in_cnt_q != 4'd0);
  assign in_act = in_valid & rst_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      in_cnt_q <= 4'd0;
      flush_q  <= '0;
    end else begin
      in_cnt_q <= in_valid ? in_cnt_q + 4'd1 : 4'd0;
      case (state_q)
        IDLE: begin
          if (in_valid) state_q <= RUN;
        end
        RUN: begin
          if (!in_valid) begin
            state_q <= FLUSH;
            flush_q <= '0;
          end
        end
        FLUSH: begin
          if (in_valid) begin
            state_q <= RUN;
          end else if (flush_q == FW'(PIPE_LAT - 1)) begin
            state_q <= IDLE;
          end else begin
            flush_q <= flush_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Entry j holds the input pair seen j cycles ago; on abort the partial frame
  // occupies entries 1..in_cnt and lands in 2..in_cnt+1 after this shift.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 1; j <= PIPE_LAT; j++) dl_q[j] <= '0;
    end else begin
      dl_q[1] <= '{vld: in_valid, cnt: in_cnt_q};
      for (int j = 2; j <= PIPE_LAT; j++) begin
        dl_q[j] <= dl_q[j-1];
        if (abort && (j <= int'(in_cnt_q) + 1)) dl_q[j].vld <= 1'b0;
      end
    end
  end

`ifdef FFT_CTRL_ERR_EN
  logic err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= abort;
  end

  assign frame_err = err_q;
`else
  assign frame_err = 1'b0;
`endif

  assign in_ready = 1'b1;

  assign butter_mode = {dl_q[L5].vld, dl_q[L4].vld, dl_q[L3].vld, dl_q[L2].vld, in_act};

  // Stage s swaps on in_cnt bit (5-s) of its own tap; stage 1 uses bit 3 at the input.
  assign state_com_mode = {dl_q[L5].vld & dl_q[L5].cnt[0],
                           dl_q[L4].vld & dl_q[L4].cnt[1],
                           dl_q[L3].vld & dl_q[L3].cnt[2],
                           dl_q[L2].vld & dl_q[L2].cnt[3],
                           in_act & in_cnt_q[3]};

  assign state5_com_flag = dl_q[L5].vld;
  assign out_valid       = dl_q[PIPE_LAT].vld;
  assign out_last        = dl_q[PIPE_LAT].vld & (dl_q[PIPE_LAT].cnt == 4'hF);

endmodule

// File: tb/tb_fft_ctrl.sv
// Directed bench for fft_ctrl: single, back-to-back, aborted, flush-restart and
// mid-frame-reset frames, checked every cycle against per-tap frame bookkeeping.
module tb_fft_ctrl;

  localparam int L2 = 16;
  localparam int L3 = 32;
  localparam int L4 = 40;
  localparam int L5 = 44;
  localparam int PL = 46;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [4:0] state_com_mode;
  logic [4:0] butter_mode;
  logic       state5_com_flag;
  logic       out_valid;
  logic       out_last;
  logic       frame_err;

  always #5 clk = ~clk;

  fft_ctrl #(.L2(L2), .L3(L3), .L4(L4), .L5(L5), .PIPE_LAT(PL)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .state_com_mode (state_com_mode),
    .butter_mode    (butter_mode),
    .state5_com_flag(state5_com_flag),
    .out_valid      (out_valid),
    .out_last       (out_last),
    .frame_err      (frame_err)
  );

  typedef struct {
    int start;
    int len;
  } frm_t;

  frm_t frames[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  // Pair present at delay L in cycle c; partial frames never reach taps >= L2.
  task automatic tap(input int c, input int l, output bit v, output int cnt);
    v   = 1'b0;
    cnt = 0;
    foreach (frames[i]) begin
      if ((l == 0 || frames[i].len == 16) && (c - l >= frames[i].start) &&
          (c - l < frames[i].start + frames[i].len)) begin
        v   = 1'b1;
        cnt = c - l - frames[i].start;
      end
    end
  endtask

  task automatic check_cycle();
    int         ls[5] = '{0, L2, L3, L4, L5};
    int         bi[5] = '{3, 3, 2, 1, 0};
    bit         v;
    int         cn;
    logic [4:0] eb;
    logic [4:0] ec;
    logic       ev;
    logic       el;
    logic       ee;
    for (int s = 0; s < 5; s++) begin
      tap(cyc, ls[s], v, cn);
      eb[s] = v;
      ec[s] = v & cn[bi[s]];
    end
    tap(cyc, PL, v, cn);
    ev = v;
    el = v && (cn == 15);
    ee = 1'b0;
`ifdef FFT_CTRL_ERR_EN
    foreach (frames[i]) if (frames[i].len < 16 && cyc == frames[i].start + frames[i].len + 1) ee = 1'b1;
`endif
    chk("in_ready", in_ready, 1);
    chk("butter_mode", butter_mode, eb);
    chk("state_com_mode", state_com_mode, ec);
    chk("state5_com_flag", state5_com_flag, eb[4]);
    chk("out_valid", out_valid, ev);
    chk("out_last", out_last, el);
    chk("frame_err", frame_err, ee);
  endtask

  task automatic step(input bit v);
    in_valid = v;
    @(negedge clk);
    check_cycle();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic send_frame(input int len);
    frames.push_back('{start: cyc, len: len});
    repeat (len) step(1'b1);
  endtask

  task automatic chk_all_zero(input string pfx);
    chk({pfx, "_in_ready"}, in_ready, 1);
    chk({pfx, "_butter_mode"}, butter_mode, 0);
    chk({pfx, "_state_com_mode"}, state_com_mode, 0);
    chk({pfx, "_state5_com_flag"}, state5_com_flag, 0);
    chk({pfx, "_out_valid"}, out_valid, 0);
    chk({pfx, "_out_last"}, out_last, 0);
    chk({pfx, "_frame_err"}, frame_err, 0);
  endtask

  initial begin
    #12;
    chk_all_zero("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Single frame: outputs 46..61, last at 61.
    send_frame(16);
    repeat (60) step(1'b0);

    // Three back-to-back frames.
    send_frame(16);
    send_frame(16);
    send_frame(16);
    repeat (60) step(1'b0);

    // Abort after 7 pairs.
    send_frame(7);
    repeat (60) step(1'b0);

    // Abort, then restart while still flushing.
    send_frame(7);
    repeat (5) step(1'b0);
    send_frame(16);
    repeat (60) step(1'b0);

    // Asynchronous reset 30 cycles into a frame.
    send_frame(16);
    repeat (14) step(1'b0);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("async_rst");
    frames.delete();
    @(posedge clk);
    @(posedge clk);
    #1;
    chk_all_zero("rst_hold");
    rst_n = 1'b1;
    cyc += 3;
    send_frame(16);
    repeat (60) step(1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
